// File: rtl/apb_mem_ctrl.sv
// APB slave in front of a byte-addressable register-file memory.
// Little-endian byte lanes, configurable wait states, out-of-range accesses flagged with pslverr.
module apb_mem_ctrl #(
    parameter int NumWords   = 64,
    parameter int WaitStates = 1
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int AW = $clog2(NumWords);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [3:0]    cnt_q;
    logic [AW-1:0] base_q;
    logic          wr_q;
    logic          err_q;
    logic [31:0]   wdata_q;
    logic [3:0]    strb_q;

    logic [7:0]    mem [NumWords];

    logic          setup;
    logic [1:0]    top_lane;
    logic [AW:0]   reach;
    logic          setup_err;
    logic [AW-1:0] acc_base;
    logic          acc_err;
    logic          enter_done;
    logic          commit;
    logic [31:0]   rd_word;

    // Upper address bits alias onto the same storage.
    logic unused_paddr;
    assign unused_paddr = ^paddr[31:AW];

    assign setup = (state_q == S_IDLE) && psel && !penable;

    always_comb begin
        if (!pwrite)        top_lane = 2'd3;
        else if (pstrb[3])  top_lane = 2'd3;
        else if (pstrb[2])  top_lane = 2'd2;
        else if (pstrb[1])  top_lane = 2'd1;
        else                top_lane = 2'd0;
    end

    // The carry out of the widened sum marks a lane past the end of memory.
    assign reach     = {1'b0, paddr[AW-1:0]} + (AW+1)'(top_lane);
    assign setup_err = reach[AW];

    // With zero wait states DONE is entered straight from SETUP, before base/err are latched.
    assign acc_base = (state_q == S_IDLE) ? paddr[AW-1:0] : base_q;
    assign acc_err  = (state_q == S_IDLE) ? setup_err : err_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (setup) state_d = (WaitStates == 0) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (!psel)              state_d = S_IDLE;
                else if (cnt_q <= 4'd1) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_done = (state_d == S_DONE);
    assign commit     = (state_q == S_DONE) && psel && penable && wr_q && !err_q;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            rd_word[8*i +: 8] = mem[acc_base + AW'(i)];
        end
    end

    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!presetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state_q <= state_d;
            if (setup) begin
                base_q  <= paddr[AW-1:0];
                wr_q    <= pwrite;
                err_q   <= setup_err;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
                cnt_q   <= 4'(WaitStates);
            end else if ((state_q == S_WAIT) && psel) begin
                cnt_q <= cnt_q - 4'd1;
            end
            pready  <= enter_done;
            pslverr <= enter_done && acc_err;
            prdata  <= (enter_done && !acc_err) ? rd_word : '0;
        end
    end

    always_ff @(posedge pclk) begin
        // NOTE: this storage is architecturally cleared by reset, so it cannot map to a RAM macro.
        if (!presetn) begin
            for (int i = 0; i < NumWords; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) mem[base_q + AW'(i)] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// Bench for apb_mem_ctrl: three instances (1, 0 and 3 wait states) checked every cycle against
// a transaction-level memory model, plus literal expectations for the directed scenarios.
module tb_apb_mem_ctrl;

    localparam int NW = 64;

    logic        pclk;
    logic        presetn;
    logic [2:0]  psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr  [3];
    logic [31:0] pwdata [3];
    logic [3:0]  pstrb  [3];
    logic [31:0] prdata [3];

    int          cyc;
    bit          chk_en;
    int          n_tests;
    int          n_fail;

    logic [7:0]  mdl [3][NW];
    logic [32:0] expq [int];

    logic [31:0] g_data;
    logic        g_err;
    int          g_lat;
    int          g_cyc;

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_mem_ctrl #(
            .NumWords  (NW),
            .WaitStates((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .pclk   (pclk),
            .presetn(presetn),
            .psel   (psel[g]),
            .penable(penable[g]),
            .pwrite (pwrite[g]),
            .paddr  (paddr[g]),
            .pwdata (pwdata[g]),
            .pstrb  (pstrb[g]),
            .prdata (prdata[g]),
            .pready (pready[g]),
            .pslverr(pslverr[g])
        );
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Every cycle, each DUT either shows the scheduled completion or all-zero outputs.
    always @(negedge pclk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                int          key;
                logic [33:0] want;
                key = cyc * 4 + d;
                if (expq.exists(key)) begin
                    want = {1'b1, expq[key]};
                    expq.delete(key);
                end else begin
                    want = '0;
                end
                check($sformatf("scb_dut%0d_cyc%0d", d, cyc),
                      64'({pready[d], pslverr[d], prdata[d]}), 64'(want));
            end
        end
    end

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < NW; a++) mdl[d][a] = 8'h00;
    endtask

    // Called just after a falling edge; returns just after a falling edge with the bus idle.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int abort_k, input int rst_k);
        int          ws, n, base, top, key;
        bit          err;
        logic [31:0] word;
        ws   = ws_of(d);
        base = int'(addr % 32'(NW));
        top  = 3;
        if (wr) begin
            top = 0;
            for (int i = 0; i < 4; i++) if (strb[i]) top = i;
        end
        err = (base + top) >= NW;
        for (int i = 0; i < 4; i++) word[8*i +: 8] = mdl[d][(base + i) % NW];
        if (err) word = '0;

        n          = cyc;
        key        = (n + 1 + ws) * 4 + d;
        expq[key]  = {err, word};
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = data;
        pstrb[d]   = strb;
        g_data = '0;
        g_err  = 1'b0;
        g_lat  = 0;
        g_cyc  = 0;

        @(negedge pclk);
        penable[d] = 1'b1;

        if (abort_k > 0) begin
            repeat (abort_k - 1) @(negedge pclk);
            expq.delete(key);
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
            @(negedge pclk);
        end else if (rst_k > 0) begin
            repeat (rst_k - 1) @(negedge pclk);
            expq.delete(key);
            presetn = 1'b0;
            @(negedge pclk);
            presetn    = 1'b1;
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
            clear_model();
            check("pready_after_reset", 64'(pready[d]), 64'd0);
        end else begin
            g_lat = 1;
            while (!pready[d] && g_lat < ws + 8) begin
                @(negedge pclk);
                g_lat++;
            end
            if (!pready[d]) check($sformatf("pready_timeout_dut%0d", d), 64'd0, 64'd1);
            g_data = prdata[d];
            g_err  = pslverr[d];
            g_cyc  = cyc;
            @(negedge pclk);
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
            if (wr && !err) begin
                for (int i = 0; i < 4; i++)
                    if (strb[i]) mdl[d][(base + i) % NW] = data[8*i +: 8];
            end
        end
    endtask

    task automatic wr(input int d, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        xfer(d, 1'b1, addr, data, strb, 0, 0);
    endtask

    task automatic rd(input int d, input logic [31:0] addr);
        xfer(d, 1'b0, addr, 32'h0, 4'h0, 0, 0);
    endtask

    initial begin
        int c1;
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        cyc     = 0;
        presetn = 1'b0;
        psel    = '0;
        penable = '0;
        pwrite  = '0;
        for (int d = 0; d < 3; d++) begin
            paddr[d]  = '0;
            pwdata[d] = '0;
            pstrb[d]  = '0;
        end
        clear_model();
        repeat (3) @(negedge pclk);
        check("reset_pready",  64'(pready),    64'd0);
        check("reset_pslverr", 64'(pslverr),   64'd0);
        check("reset_prdata",  64'(prdata[0]), 64'd0);
        presetn = 1'b1;
        chk_en  = 1'b1;

        // Full write then read, one wait state.
        wr(0, 32'h10, 32'hAABBCCDD, 4'b1111);
        check("full_wr_lat", 64'(g_lat), 64'd2);
        check("full_wr_err", 64'(g_err), 64'd0);
        rd(0, 32'h10);
        check("full_rd_data", 64'(g_data), 64'hAABBCCDD);
        check("full_rd_err",  64'(g_err),  64'd0);

        // Partial strobes.
        wr(0, 32'h20, 32'h11223344, 4'b0101);
        rd(0, 32'h20);
        check("partial_rd_data", 64'(g_data), 64'h00220044);

        // End-of-memory boundary.
        wr(0, 32'h3C, 32'h55667788, 4'b1111);
        wr(0, 32'h3E, 32'hDEADBEEF, 4'b1111);
        check("bound_wr_err", 64'(g_err), 64'd1);
        rd(0, 32'h3C);
        check("bound_unchanged", 64'(g_data), 64'h55667788);
        wr(0, 32'h3E, 32'h00009911, 4'b0011);
        check("bound_wr_ok_err", 64'(g_err), 64'd0);
        rd(0, 32'h3C);
        check("bound_partial_data", 64'(g_data), 64'h99117788);
        rd(0, 32'h3D);
        check("bound_rd_err",  64'(g_err),  64'd1);
        check("bound_rd_data", 64'(g_data), 64'd0);
        rd(0, 32'h3C);
        check("bound_rd_ok_err", 64'(g_err), 64'd0);
        wr(0, 32'h3F, 32'hFFFFFFFF, 4'b0000);
        check("zero_strb_err", 64'(g_err), 64'd0);
        rd(0, 32'h3C);
        check("zero_strb_nowrite", 64'(g_data), 64'h99117788);

        // Aliasing of upper address bits.
        wr(0, 32'h1000_0010, 32'hCAFEF00D, 4'b1111);
        rd(0, 32'h10);
        check("alias_rd_data", 64'(g_data), 64'hCAFEF00D);

        // Zero wait states.
        wr(1, 32'h04, 32'h12345678, 4'b1111);
        check("ws0_wr_lat", 64'(g_lat), 64'd1);
        rd(1, 32'h04);
        check("ws0_rd_lat",  64'(g_lat),  64'd1);
        check("ws0_rd_data", 64'(g_data), 64'h12345678);

        // Three wait states and back-to-back spacing.
        wr(2, 32'h30, 32'hA5A5A5A5, 4'b1111);
        check("ws3_wr_lat", 64'(g_lat), 64'd4);
        c1 = g_cyc;
        wr(2, 32'h34, 32'h01010101, 4'b1111);
        check("ws3_b2b_spacing", 64'(g_cyc - c1), 64'd5);

        // Aborted transfers write nothing.
        xfer(2, 1'b1, 32'h30, 32'h5A5A5A5A, 4'b1111, 2, 0);
        rd(2, 32'h30);
        check("abort_ws3_data", 64'(g_data), 64'hA5A5A5A5);
        xfer(0, 1'b1, 32'h10, 32'h00000000, 4'b1111, 1, 0);
        rd(0, 32'h10);
        check("abort_ws1_data", 64'(g_data), 64'hCAFEF00D);

        // Reset during WAIT drops the write and clears memory.
        wr(0, 32'h08, 32'h01020304, 4'b1111);
        rd(0, 32'h08);
        check("pre_reset_data", 64'(g_data), 64'h01020304);
        xfer(0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'b1111, 0, 1);
        rd(0, 32'h08);
        check("post_reset_data", 64'(g_data), 64'd0);
        rd(2, 32'h30);
        check("post_reset_other_dut", 64'(g_data), 64'd0);

        // Randomized traffic against the model.
        for (int t = 0; t < 450; t++) begin
            int          d, ab;
            bit          w;
            logic [31:0] a;
            d  = $urandom_range(0, 2);
            w  = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = {a[31:6], 6'($urandom_range(56, 63))};
            ab = 0;
            if (ws_of(d) > 0 && $urandom_range(0, 9) == 0) ab = $urandom_range(1, ws_of(d));
            xfer(d, w, a, $urandom, 4'($urandom_range(0, 15)), ab, 0);
            if ($urandom_range(0, 3) == 0) @(negedge pclk);
        end

        repeat (4) @(negedge pclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
